// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared source encoding and register-address width for the writeback arbiter
package wb_arb_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {SRC_ALU = 1'b0, SRC_MULT = 1'b1} wb_src_e;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: synchronous per-source FIFO with full/empty derived from a registered count
// ports: clock, reset, push/push_data (write), pop (read), head (oldest entry), full, empty
module wb_src_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  always_ff @(posedge clock)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_data;
  assign head = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between ALU and MULT writeback streams
// ports: clock/reset; alu_* and mult_* valid/ready result streams; registered wb_* beat with
// wb_src (0 ALU, 1 MULT); with WB_PORT_ARBITER_STATS_EN also stat_conflicts and stat_forced
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic                  alu_regwrite,
  input  logic                  mult_valid,
  output logic                  mult_ready,
  input  logic [DATA_WIDTH-1:0] mult_result,
  input  logic [REG_ADDR_W-1:0] mult_rd,
  input  logic                  mult_regwrite,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_regwrite,
  output logic                  wb_src
`ifdef WB_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]           stat_conflicts,
  output logic [31:0]           stat_forced
`endif
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    reg_addr_t             rd;
  } entry_t;
  localparam int WW = $clog2(MAX_WAIT + 1);
  entry_t alu_head, mult_head;
  logic alu_full, alu_empty, mult_full, mult_empty;
  logic alu_push, mult_push, grant_alu, grant_mult, forced;
  logic [WW-1:0] alu_wait;
  assign alu_ready = !alu_full && !reset;
  assign mult_ready = !mult_full && !reset;
  // entries that will never write the register file are consumed here
  assign alu_push = alu_valid && alu_ready && alu_regwrite && alu_rd != '0;
  assign mult_push = mult_valid && mult_ready && mult_regwrite && mult_rd != '0;
  assign forced = !alu_empty && !mult_empty && alu_wait == WW'(MAX_WAIT);
  assign grant_mult = !mult_empty && !forced;
  assign grant_alu = !alu_empty && !grant_mult;
  wb_src_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clock(clock), .reset(reset), .push(alu_push), .push_data({alu_result, alu_rd}),
    .pop(grant_alu), .head(alu_head), .full(alu_full), .empty(alu_empty)
  );
  wb_src_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_mult_fifo (
    .clock(clock), .reset(reset), .push(mult_push), .push_data({mult_result, mult_rd}),
    .pop(grant_mult), .head(mult_head), .full(mult_full), .empty(mult_empty)
  );
  always_ff @(posedge clock)
    if (reset) alu_wait <= '0;
    else alu_wait <= (alu_empty || grant_alu) ? '0 :
                     (alu_wait == WW'(MAX_WAIT)) ? alu_wait : alu_wait + WW'(1);
  always_ff @(posedge clock)
    if (reset) begin
      wb_valid <= 1'b0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_src <= SRC_ALU;
    end else begin
      wb_valid <= grant_alu || grant_mult;
      if (grant_alu || grant_mult) begin
        wb_data <= grant_mult ? mult_head.data : alu_head.data;
        wb_rd <= grant_mult ? mult_head.rd : alu_head.rd;
        wb_src <= grant_mult ? SRC_MULT : SRC_ALU;
      end
    end
  assign wb_regwrite = wb_valid;
`ifdef WB_PORT_ARBITER_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      stat_conflicts <= '0;
      stat_forced <= '0;
    end else begin
      stat_conflicts <= stat_conflicts + 32'(!alu_empty && !mult_empty);
      stat_forced <= stat_forced + 32'(forced);
    end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus checked against a queue-based reference model
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;
  localparam int DW = 32, D = 2, MW = 3;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;
  logic alu_valid = 0, alu_regwrite = 0, mult_valid = 0, mult_regwrite = 0;
  logic [DW-1:0] alu_result = '0, mult_result = '0;
  logic [4:0] alu_rd = '0, mult_rd = '0;
  logic alu_ready, mult_ready, wb_valid, wb_regwrite, wb_src;
  logic [DW-1:0] wb_data;
  logic [4:0] wb_rd;
`ifdef WB_PORT_ARBITER_STATS_EN
  logic [31:0] stat_conflicts, stat_forced;
  logic [31:0] e_conf = '0, e_forced = '0;
`endif
  wb_port_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_rd(alu_rd), .alu_regwrite(alu_regwrite),
    .mult_valid(mult_valid), .mult_ready(mult_ready), .mult_result(mult_result),
    .mult_rd(mult_rd), .mult_regwrite(mult_regwrite),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_src(wb_src)
`ifdef WB_PORT_ARBITER_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
`endif
  );
  int errors = 0, checks = 0;
  logic [DW+4:0] aq[$], mq[$];
  int wait_n = 0;
  logic e_valid = 0, e_src = 0;
  logic [DW-1:0] e_data = '0;
  logic [4:0] e_rd = '0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic av, input logic [DW-1:0] ad, input logic [4:0] ard,
                      input logic arw, input logic mv, input logic [DW-1:0] md,
                      input logic [4:0] mrd, input logic mrw);
    logic a_acc, m_acc, an, mn;
    @(negedge clock);
    check("wb_valid", wb_valid, e_valid);
    check("wb_regwrite", wb_regwrite, e_valid);
    check("wb_data", wb_data, e_data);
    check("wb_rd", wb_rd, e_rd);
    check("wb_src", wb_src, e_src);
    check("alu_ready", alu_ready, !reset && aq.size() < D);
    check("mult_ready", mult_ready, !reset && mq.size() < D);
`ifdef WB_PORT_ARBITER_STATS_EN
    check("stat_conflicts", stat_conflicts, e_conf);
    check("stat_forced", stat_forced, e_forced);
`endif
    reset = r;
    alu_valid = av; alu_result = ad; alu_rd = ard; alu_regwrite = arw;
    mult_valid = mv; mult_result = md; mult_rd = mrd; mult_regwrite = mrw;
    if (r) begin
      aq.delete(); mq.delete();
      wait_n = 0; e_valid = 0; e_data = '0; e_rd = '0; e_src = 0;
`ifdef WB_PORT_ARBITER_STATS_EN
      e_conf = '0; e_forced = '0;
`endif
    end else begin
      a_acc = av && aq.size() < D;
      m_acc = mv && mq.size() < D;
      an = aq.size() > 0;
      mn = mq.size() > 0;
`ifdef WB_PORT_ARBITER_STATS_EN
      if (an && mn) e_conf++;
      if (an && mn && wait_n == MW) e_forced++;
`endif
      if (mn && !(an && wait_n == MW)) begin
        {e_data, e_rd} = mq.pop_front(); e_src = 1; e_valid = 1;
      end else if (an) begin
        {e_data, e_rd} = aq.pop_front(); e_src = 0; e_valid = 1;
      end else e_valid = 0;
      wait_n = (an && e_valid && e_src) ? (wait_n < MW ? wait_n + 1 : MW) : 0;
      if (a_acc && arw && ard != 0) aq.push_back({ad, ard});
      if (m_acc && mrw && mrd != 0) mq.push_back({md, mrd});
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask
  initial begin
    step(1, 0, '0, '0, 0, 0, '0, '0, 0);
    step(0, 1, 32'h11, 5'd3, 1, 0, '0, '0, 0);
    idle(4);
    step(0, 1, 32'hA, 5'd5, 1, 1, 32'hB, 5'd6, 1);
    idle(4);
    step(0, 1, 32'hA1, 5'd7, 1, 1, 32'h100, 5'd8, 1);
    for (int i = 1; i < 10; i++) step(0, 0, '0, '0, 0, 1, 32'h100 + i, 5'd8, 1);
    idle(4);
    for (int i = 0; i < 16; i++) step(0, 1, 32'h200 + i, 5'd9, 1, 1, 32'h300 + i, 5'd10, 1);
    idle(6);
    step(0, 1, 32'h55, 5'd0, 1, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0, 1, 32'h66, 5'd4, 0);
    idle(4);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h400 + i, 5'd11, 1, 1, 32'h500 + i, 5'd12, 1);
    step(1, 0, '0, '0, 0, 0, '0, '0, 0);
    idle(5);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(0, 9) != 0);
    idle(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the ALU writeback stream and the MULT pipe writeback stream.
- Each source feeds a small per-source FIFO. An aging-aware fixed-priority arbiter drains one entry per cycle into a registered writeback output.
- Replaces the fixed 2-cycle MULT offset scheme: collisions are resolved by arbitration and backpressure, not by timing.

Parameters:
- DATA_WIDTH, 32, width of result data.
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2).
- MAX_WAIT, 3, consecutive cycles an ALU head may lose before it is forced to win.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU FIFO can accept.
- alu_result  in  DATA_WIDTH  ALU result.
- alu_rd  in  5  ALU destination register.
- alu_regwrite  in  1  ALU write enable.
- mult_valid  in  1  MULT result offered.
- mult_ready  out  1  MULT FIFO can accept.
- mult_result  in  DATA_WIDTH  MULT result.
- mult_rd  in  5  MULT destination register.
- mult_regwrite  in  1  MULT write enable.
- wb_valid  out  1  writeback beat valid.
- wb_data  out  DATA_WIDTH  writeback data.
- wb_rd  out  5  writeback register.
- wb_regwrite  out  1  register-file write enable (equals wb_valid).
- wb_src  out  1  granted source: 0 = ALU, 1 = MULT.

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - Both FIFOs empty, pointers and wait counter cleared.
  - wb_valid, wb_regwrite, wb_src = 0; wb_data, wb_rd = 0.
  - alu_ready and mult_ready = 0 during the reset cycle, 1 on the first cycle after.
  - Reset mid-operation discards all queued entries with no writeback.
- Acceptance:
  - An entry is accepted on a cycle where x_valid & x_ready.
  - x_ready = !full, computed from registered state only. A full FIFO is not ready even if it dequeues that cycle (no comb path valid→ready).
- Filtering:
  - An accepted entry with regwrite = 0 or rd = 0 is consumed and not enqueued; it never produces a writeback.
- Arbitration (each cycle, among non-empty FIFO heads):
  - Only MULT non-empty: grant MULT.
  - Only ALU non-empty: grant ALU.
  - Both non-empty: grant MULT unless alu_wait == MAX_WAIT, then grant ALU.
  - alu_wait:
    - Increments when the ALU head is non-empty and loses.
    - Resets to 0 when ALU is granted or its FIFO is empty.
    - Saturates at MAX_WAIT.
- Output:
  - The granted head is popped and registered into the wb_* outputs the next cycle. Latency from accept to wb_valid is ≥2 cycles: accept edge, then pop/register edge.
  - wb_valid is high exactly one cycle per popped entry. With no grant, wb_valid = 0 and the data/rd outputs hold their last value.
- Simultaneous events:
  - Enqueue and pop on the same FIFO in one cycle are both legal (non-full case); count is unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Ordering:
  - Per-source order is preserved.
  - Cross-source order for the same rd is not guaranteed; the issue scoreboard forbids overlapping writers.
- Throughput: sustained 1 writeback/cycle while any FIFO is non-empty.

Optional Feature:
- Macro WB_PORT_ARBITER_STATS_EN.
- With the macro: extra output stat_conflicts (out, 32) counts cycles where both heads are non-empty; extra output stat_forced (out, 32) counts MAX_WAIT-forced ALU grants. Both wrap modulo 2^32 and clear on reset.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package wb_arb_pkg:
  - SRC_ALU = 0, SRC_MULT = 1.
  - REG_ADDR_W = 5.
  - Entry record: data + rd.
- Sub-module wb_src_fifo:
  - Parameterised synchronous FIFO with registered full/empty, instantiated twice.
  - The arbiter, wait counter and output register live in the top.

Test Plan:
- ALU only: alu_result = 0x11, rd = 3 accepted at cycle 1 → wb_valid at cycle 3, wb_data = 0x11, wb_rd = 3, wb_src = 0.
- Both sources same cycle: ALU 0xA/rd 5 and MULT 0xB/rd 6 → MULT written first, ALU one cycle later; 2 consecutive wb_valid beats.
- Starvation: hold mult_valid continuously with distinct results, one ALU entry queued → ALU granted after exactly MAX_WAIT = 3 MULT grants.
- Backpressure: hold mult_valid with no drain relief (ALU forced wins interleaved) until mult_ready = 0 at 2 entries → no accept while full; ready returns the cycle after a pop; no entry lost or duplicated.
- Filtering: alu_rd = 0, then mult_regwrite = 0 → both accepted, wb_valid never asserts.
- Reset mid-stream: reset asserted with 2 entries queued in each FIFO → all outputs 0 next cycle; no wb_valid afterwards until new input.
